pixel_output_stage: RTL and testbench

Parametrised colour output stage between the PPU and the TT output pins. It replaces the fixed two-colour display logic in the top level. It merges a configurable number of prioritised pixel layers through a writable palette and drives registered RGB with sync signals delay-matched to it. A frame-synchronous collision-flash state machine blinks the background with a cooldown, so the display never tears mid-frame.

---
 rtl/pixel_output_stage.sv | 167 ++++++++++++++++
 tb/tb_pixel_output_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_output_stage.sv
// Colour output stage: prioritised layers through a writable palette,
// registered RGB with delay-matched syncs and a frame-synchronous collision flash.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pixel_layers          layer lit bits, lowest index has priority
//   video_active          display-on qualifier
//   hsync_in, vsync_in    raw syncs, delayed one cycle to hsync_out/vsync_out
//   frame_end             one-cycle pulse per frame; the FSM only moves on it
//   collision             level, sampled only on frame_end
//   pal_wr_en/addr/data   palette write port, data packed {R,G,B}
//   R, G, B               registered colour
//   flash_active          high while the FSM is in FLASH
module pixel_output_stage #(
    parameter int COLOUR_BITS     = 2,
    parameter int LAYERS          = 2,
    parameter int FLASH_FRAMES    = 16,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int BLINK_LOG2      = 2,
    localparam int AW             = $clog2(LAYERS + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LAYERS-1:0]        pixel_layers,
    input  logic                     video_active,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     frame_end,
    input  logic                     collision,
    input  logic                     pal_wr_en,
    input  logic [AW-1:0]            pal_wr_addr,
    input  logic [3*COLOUR_BITS-1:0] pal_wr_data,
    output logic [COLOUR_BITS-1:0]   R,
    output logic [COLOUR_BITS-1:0]   G,
    output logic [COLOUR_BITS-1:0]   B,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     flash_active
);

    localparam int NENT = LAYERS + 2;
    localparam int CW   = 3 * COLOUR_BITS;
    localparam int MAXF = (FLASH_FRAMES > COOLDOWN_FRAMES) ?
                          FLASH_FRAMES : COOLDOWN_FRAMES;
    localparam int EW   = $clog2(MAXF) + 1;

    localparam logic [EW-1:0] FLASH_LAST = EW'(FLASH_FRAMES - 1);
    localparam logic [EW-1:0] COOL_LAST  = EW'(COOLDOWN_FRAMES - 1);

    localparam logic [COLOUR_BITS-1:0] CMAX = '1;
    localparam logic [COLOUR_BITS-1:0] CNIL = '0;
    localparam logic [CW-1:0] RST_LAYER  = '1;
    localparam logic [CW-1:0] RST_NORMAL = {CNIL, CMAX, CNIL};
    localparam logic [CW-1:0] RST_ALERT  = {CMAX, CNIL, CNIL};

    typedef enum logic [1:0] {
        IDLE,
        FLASH,
        COOLDOWN
    } state_e;

    state_e         state_q, state_d;
    logic [EW-1:0]  elapsed_q, elapsed_d;
    logic [CW-1:0]  pal_q [NENT];
    logic [CW-1:0]  pal_d [NENT];
    logic [CW-1:0]  rgb_q, rgb_d;
    logic           hs_q, vs_q;
    logic           blink_hi;

    function automatic logic [CW-1:0] rst_entry(input int idx);
        if (idx < LAYERS)       return RST_LAYER;
        else if (idx == LAYERS) return RST_NORMAL;
        else                    return RST_ALERT;
    endfunction

    // Shifting past the counter width yields 0, so an oversized
    // BLINK_LOG2 simply keeps the alert colour for the whole flash.
    assign blink_hi = |(elapsed_q & (EW'(1) << BLINK_LOG2));

    // Out-of-range addresses match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            pal_d[i] = pal_q[i];
            if (pal_wr_en && (pal_wr_addr == AW'(i)))
                pal_d[i] = pal_wr_data;
        end
    end

    // Reads use pal_q, so a same-edge write shows only from the next pixel.
    always_comb begin
        if (state_q == FLASH && !blink_hi)
            rgb_d = pal_q[LAYERS+1];
        else
            rgb_d = pal_q[LAYERS];
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (pixel_layers[i])
                rgb_d = pal_q[i];
        end
        if (!video_active)
            rgb_d = '0;
    end

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (collision) begin
                        state_d   = FLASH;
                        elapsed_d = '0;
                    end
                end
                FLASH: begin
                    if (collision) begin
                        elapsed_d = '0;
                    end else if (elapsed_q == FLASH_LAST) begin
                        state_d   = COOLDOWN;
                        elapsed_d = '0;
                    end else begin
                        elapsed_d = elapsed_q + EW'(1);
                    end
                end
                COOLDOWN: begin
                    if (elapsed_q == COOL_LAST) begin
                        state_d   = IDLE;
                        elapsed_d = '0;
                    end else begin
                        elapsed_d = elapsed_q + EW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    elapsed_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            elapsed_q <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            for (int i = 0; i < NENT; i++)
                pal_q[i] <= rst_entry(i);
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            rgb_q     <= rgb_d;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
            for (int i = 0; i < NENT; i++)
                pal_q[i] <= pal_d[i];
        end
    end

    assign R            = rgb_q[CW-1 -: COLOUR_BITS];
    assign G            = rgb_q[2*COLOUR_BITS-1 -: COLOUR_BITS];
    assign B            = rgb_q[COLOUR_BITS-1:0];
    assign hsync_out    = hs_q;
    assign vsync_out    = vs_q;
    assign flash_active = (state_q == FLASH);

endmodule

// File: tb/tb_pixel_output_stage.sv
// Scoreboard bench for pixel_output_stage: random and directed stimulus
// against a frame-level reference model; second instance checks address range.
module tb_pixel_output_stage;

    localparam int FF = 8;
    localparam int CF = 4;
    localparam int BL = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] lay = '0;
    logic       va = 1'b0, hs = 1'b0, vs = 1'b0;
    logic       fe = 1'b0, col = 1'b0;
    logic       we = 1'b0;
    logic [1:0] wa = '0;
    logic [5:0] wd = '0;
    logic [1:0] R, G, B;
    logic       hso, vso, fa;

    logic [2:0] l3 = '0;
    logic       we3 = 1'b0;
    logic [2:0] wa3 = '0;
    logic [5:0] wd3 = '0;
    logic [1:0] R3, G3, B3;
    logic       hso3, vso3, fa3;

    always #5 clk = ~clk;

    pixel_output_stage #(
        .COLOUR_BITS(2), .LAYERS(2), .FLASH_FRAMES(FF),
        .COOLDOWN_FRAMES(CF), .BLINK_LOG2(BL)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pixel_layers(lay),
        .video_active(va), .hsync_in(hs), .vsync_in(vs),
        .frame_end(fe), .collision(col), .pal_wr_en(we),
        .pal_wr_addr(wa), .pal_wr_data(wd),
        .R(R), .G(G), .B(B), .hsync_out(hso), .vsync_out(vso),
        .flash_active(fa)
    );

    pixel_output_stage #(
        .COLOUR_BITS(2), .LAYERS(3), .FLASH_FRAMES(FF),
        .COOLDOWN_FRAMES(CF), .BLINK_LOG2(BL)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .pixel_layers(l3),
        .video_active(1'b1), .hsync_in(1'b0), .vsync_in(1'b0),
        .frame_end(1'b0), .collision(1'b0), .pal_wr_en(we3),
        .pal_wr_addr(wa3), .pal_wr_data(wd3),
        .R(R3), .G(G3), .B(B3), .hsync_out(hso3), .vsync_out(vso3),
        .flash_active(fa3)
    );

    typedef struct packed {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       fa;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: palette contents, flash phase and frame counter.
    logic [5:0] m_pal [4];
    int         m_st;   // 0 idle, 1 flash, 2 cooldown
    int         m_el;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pal[0] = 6'h3f;
        m_pal[1] = 6'h3f;
        m_pal[2] = 6'b00_11_00;
        m_pal[3] = 6'b11_00_00;
        m_st = 0;
        m_el = 0;
    endtask

    task automatic drive(input logic [1:0] l, input logic v, input logic h,
                         input logic vv, input logic f, input logic c,
                         input logic w, input logic [1:0] a,
                         input logic [5:0] d);
        exp_t e;
        logic [5:0] cexp;
        bit hit;
        @(negedge clk);
        lay = l; va = v; hs = h; vs = vv; fe = f; col = c;
        we = w; wa = a; wd = d;
        hit = 0;
        cexp = '0;
        for (int i = 0; i < 2; i++)
            if (!hit && l[i]) begin
                cexp = m_pal[i];
                hit = 1;
            end
        if (!hit)
            cexp = (m_st == 1 && ((m_el / (1 << BL)) % 2) == 0) ?
                   m_pal[3] : m_pal[2];
        if (!v) cexp = '0;
        if (w) m_pal[a] = d;
        if (f) begin
            case (m_st)
                0: if (c) begin m_st = 1; m_el = 0; end
                1: begin
                    if (c) m_el = 0;
                    else if (m_el == FF - 1) begin m_st = 2; m_el = 0; end
                    else m_el++;
                end
                default: begin
                    if (m_el == CF - 1) begin m_st = 0; m_el = 0; end
                    else m_el++;
                end
            endcase
        end
        e.rgb = cexp; e.hs = h; e.vs = vv; e.fa = (m_st == 1);
        q.push_back(e);
    endtask

    task automatic px(input logic [1:0] l, input logic v, input bit rw);
        logic w;
        w = rw && ($urandom % 6 == 0);
        drive(l, v, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
              w, 2'($urandom), 6'($urandom));
    endtask

    task automatic frame(input int n, input logic c, input bit rw);
        for (int i = 0; i < n - 1; i++)
            px(($urandom % 3 == 0) ? 2'($urandom) : 2'b00,
               ($urandom % 5 != 0), rw);
        drive(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, c, 1'b0, 2'b00, 6'h0);
    endtask

    task automatic t3(input string nm, input logic [2:0] l, input logic w,
                      input logic [2:0] a, input logic [5:0] d,
                      input logic [5:0] exp);
        @(negedge clk);
        l3 = l; we3 = w; wa3 = a; wd3 = d;
        @(posedge clk);
        #1;
        check(nm, {26'd0, R3, G3, B3}, {26'd0, exp});
    endtask

    // Monitor: output is presented every active cycle; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("rgb", {26'd0, R, G, B}, {26'd0, e.rgb});
                check("sync_flash", {29'd0, hso, vso, fa},
                      {29'd0, e.hs, e.vs, e.fa});
            end
        end
    end

    initial begin
        int guard;
        m_reset();
        va = 1'b1; hs = 1'b1; vs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {26'd0, R, G, B, hso, vso, fa}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Background after reset, syncs tracking one cycle late.
        for (int i = 0; i < 4; i++)
            drive(2'b00, 1'b1, 1'(i), 1'(i >> 1), 1'b0, 1'b0,
                  1'b0, 2'b00, 6'h0);

        // Layer priority with written palette entries.
        drive(2'b00, 1'b1, 0, 0, 0, 0, 1'b1, 2'd0, 6'b01_00_00);
        drive(2'b00, 1'b1, 0, 0, 0, 0, 1'b1, 2'd1, 6'b00_00_10);
        drive(2'b11, 1'b1, 0, 0, 0, 0, 1'b0, 2'd0, 6'h0);
        drive(2'b10, 1'b1, 0, 0, 0, 0, 1'b0, 2'd0, 6'h0);
        drive(2'b11, 1'b0, 1, 1, 0, 0, 1'b0, 2'd0, 6'h0);
        // Write and render of the same entry in one cycle.
        drive(2'b01, 1'b1, 0, 0, 0, 0, 1'b1, 2'd0, 6'b11_01_10);
        drive(2'b01, 1'b1, 0, 0, 0, 0, 1'b0, 2'd0, 6'h0);

        // Flash sequence: one collision, then 8 flash + 4 cooldown frames.
        frame(4, 1'b1, 0);
        for (int i = 0; i < FF + CF + 1; i++) frame(4, 1'b0, 0);

        // Extend at the 5th flash frame, then hold collision in cooldown.
        frame(3, 1'b1, 0);
        for (int i = 0; i < 4; i++) frame(3, 1'b0, 0);
        frame(3, 1'b1, 0);
        for (int i = 0; i < FF; i++) frame(3, 1'b0, 0);
        for (int i = 0; i < CF + 1; i++) frame(3, 1'b1, 0);

        // Alert entry rewritten during flash.
        drive(2'b00, 1'b1, 0, 0, 0, 0, 1'b1, 2'd3, 6'b10_10_01);
        for (int i = 0; i < 3; i++) frame(3, 1'b0, 0);

        // Randomised frames with palette writes.
        for (int i = 0; i < 40; i++)
            frame($urandom_range(2, 7), 1'($urandom % 4 == 0), 1);

        // Asynchronous reset in the middle of a flash.
        frame(3, 1'b1, 0);
        drive(2'b00, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 2'd0, 6'h0);
        @(posedge clk);
        #3;
        check("pre_reset_flash", {31'd0, fa}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {26'd0, R, G, B, hso, vso, fa}, 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        check("held_reset", {26'd0, R, G, B, hso, vso, fa}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) frame(3, 1'b0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("drain", q.size(), 0);

        // Five-entry palette: addresses 5..7 are out of range.
        t3("oob5", 3'b000, 1'b1, 3'd5, 6'h0, 6'b00_11_00);
        t3("oob6", 3'b000, 1'b1, 3'd6, 6'h0, 6'b00_11_00);
        t3("oob7", 3'b000, 1'b1, 3'd7, 6'h0, 6'b00_11_00);
        t3("oob_bg", 3'b000, 1'b0, 3'd0, 6'h0, 6'b00_11_00);
        t3("oob_l0", 3'b001, 1'b0, 3'd0, 6'h0, 6'h3f);
        t3("oob_l2", 3'b100, 1'b0, 3'd0, 6'h0, 6'h3f);
        t3("l3_bg_old", 3'b000, 1'b1, 3'd3, 6'h15, 6'b00_11_00);
        t3("l3_bg_new", 3'b000, 1'b0, 3'd0, 6'h0, 6'h15);
        t3("l3_alert_idle", 3'b000, 1'b1, 3'd4, 6'h2a, 6'h15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
